gmii_rx_buffer: RTL and testbench

- Receive-side counterpart of the 10/100M TX adaptation path.
- Accepts a 10/100M nibble stream (one nibble per clk while valid, low nibble first) and reassembles it into bytes.
- Stores each complete frame in an internal data FIFO and its byte length in a length FIFO.
- Replays each stored frame as a contiguous GMII-style byte burst (one byte per clk), so downstream GMII logic needs no 10/100M awareness.

---
 rtl/gmii_rx_buffer.sv | 206 ++++++++++++++++++++
 tb/tb_gmii_rx_buffer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gmii_rx_buffer.sv
// Reassembles a 10/100M nibble stream into frames, buffers them, and replays each as a contiguous GMII byte burst.
// Optional rx_drop_cnt counter is enabled by defining GMII_RX_BUF_DROP_CNT_EN.
`timescale 1ns/1ps
module gmii_rx_buffer #(
    parameter int DATA_AW    = 11,
    parameter int LEN_AW     = 4,
    parameter int IFG_CYCLES = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        eth_10_100m_en,
    input  logic        link,
    input  logic        e10_100_rx_dv,
    input  logic [7:0]  e10_100_rxd,
    output logic        gmii_rx_dv,
    output logic [7:0]  gmii_rxd,
    output logic        rx_drop,
    output logic [15:0] rx_drop_cnt
);

    localparam int DEPTH  = 1 << DATA_AW;
    localparam int LDEPTH = 1 << LEN_AW;
    localparam int IFG_W  = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
    localparam logic [DATA_AW:0] PTR_ONE   = {{DATA_AW{1'b0}}, 1'b1};
    localparam logic [DATA_AW:0] DATA_FULL = {1'b1, {DATA_AW{1'b0}}};
    localparam logic [LEN_AW:0]  LEN_ONE   = {{LEN_AW{1'b0}}, 1'b1};
    localparam logic [LEN_AW:0]  LEN_FULL  = {1'b1, {LEN_AW{1'b0}}};
    localparam logic [IFG_W-1:0] IFG_ONE   = IFG_W'(1);
    localparam logic [IFG_W-1:0] IFG_LAST  = IFG_W'(IFG_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, LEN_LATCH, SEND, SEND_END, IFG} state_t;

    logic [7:0]       data_mem [DEPTH];
    logic [DATA_AW:0] len_mem  [LDEPTH];

    logic             clr, dv_in;
    logic             dv_d0_q, phase_q, bad_q, drop_q;
    logic [3:0]       low_q;
    logic [DATA_AW:0] wr_ptr_q, commit_ptr_q, byte_cnt_q;
    logic [LEN_AW:0]  len_wr_q, len_rd_q;
    logic             frame_start, frame_end, abandon, wr_attempt;
    logic             data_full, len_full, len_empty, data_we, len_push;

    state_t           state_q, state_d;
    logic [DATA_AW:0] rd_ptr_q, pack_len_q, pack_len_d, rd_cnt_q, rd_cnt_d;
    logic [IFG_W-1:0] ifg_q, ifg_d;
    logic             rd_en, len_pop, valid_q;
    logic [7:0]       rd_data_q;
    logic [DATA_AW:0] len_rdata_q;
    logic             unused_hi_nibble;

    // Link loss behaves exactly like reset, except for the drop counter.
    assign clr   = rst | ~link;
    assign dv_in = e10_100_rx_dv & eth_10_100m_en;
    assign unused_hi_nibble = ^e10_100_rxd[7:4];

    assign frame_start = dv_in & ~dv_d0_q;
    assign frame_end   = ~dv_in & dv_d0_q & eth_10_100m_en;
    assign abandon     = dv_d0_q & ~eth_10_100m_en;
    assign wr_attempt  = dv_in & phase_q;
    assign data_full   = (wr_ptr_q - rd_ptr_q) == DATA_FULL;
    assign len_full    = (len_wr_q - len_rd_q) == LEN_FULL;
    assign len_empty   = (len_wr_q == len_rd_q);
    assign data_we     = wr_attempt & ~bad_q & ~data_full & ~clr;
    assign len_push    = frame_end & ~bad_q & (byte_cnt_q != '0) & ~clr;

    always_ff @(posedge clk) begin
        if (clr) begin
            dv_d0_q      <= 1'b0;
            phase_q      <= 1'b0;
            bad_q        <= 1'b0;
            drop_q       <= 1'b0;
            low_q        <= '0;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            byte_cnt_q   <= '0;
            len_wr_q     <= '0;
        end else begin
            dv_d0_q <= dv_in;
            drop_q  <= 1'b0;
            phase_q <= dv_in ? ~phase_q : 1'b0;
            if (dv_in && !phase_q)
                low_q <= e10_100_rxd[3:0];
            if (frame_start) begin
                byte_cnt_q <= '0;
                bad_q      <= len_full;
            end
            if (wr_attempt && !bad_q) begin
                if (data_full) begin
                    bad_q <= 1'b1;
                end else begin
                    wr_ptr_q   <= wr_ptr_q + PTR_ONE;
                    byte_cnt_q <= byte_cnt_q + PTR_ONE;
                end
            end
            if (abandon) begin
                wr_ptr_q <= commit_ptr_q;
                drop_q   <= 1'b1;
                bad_q    <= 1'b0;
            end else if (frame_end) begin
                bad_q <= 1'b0;
                if (bad_q) begin
                    wr_ptr_q <= commit_ptr_q;
                    drop_q   <= 1'b1;
                end else if (byte_cnt_q != '0) begin
                    commit_ptr_q <= wr_ptr_q;
                    len_wr_q     <= len_wr_q + LEN_ONE;
                end
            end
        end
    end

    // Storage arrays carry no reset so they map onto block RAM.
    always_ff @(posedge clk) begin
        if (data_we)
            data_mem[wr_ptr_q[DATA_AW-1:0]] <= {e10_100_rxd[3:0], low_q};
        if (rd_en)
            rd_data_q <= data_mem[rd_ptr_q[DATA_AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (len_push)
            len_mem[len_wr_q[LEN_AW-1:0]] <= byte_cnt_q;
        if (len_pop)
            len_rdata_q <= len_mem[len_rd_q[LEN_AW-1:0]];
    end

    always_comb begin
        state_d    = state_q;
        pack_len_d = pack_len_q;
        rd_cnt_d   = rd_cnt_q;
        ifg_d      = ifg_q;
        rd_en      = 1'b0;
        len_pop    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!len_empty) begin
                    len_pop = 1'b1;
                    state_d = LEN_LATCH;
                end
            end
            LEN_LATCH: begin
                pack_len_d = len_rdata_q;
                rd_en      = 1'b1;
                rd_cnt_d   = PTR_ONE;
                state_d    = (len_rdata_q == PTR_ONE) ? SEND_END : SEND;
            end
            SEND: begin
                rd_en    = 1'b1;
                rd_cnt_d = rd_cnt_q + PTR_ONE;
                if (rd_cnt_d == pack_len_q)
                    state_d = SEND_END;
            end
            SEND_END: begin
                ifg_d   = '0;
                state_d = IFG;
            end
            IFG: begin
                ifg_d = ifg_q + IFG_ONE;
                if (ifg_q == IFG_LAST)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q    <= IDLE;
            pack_len_q <= '0;
            rd_cnt_q   <= '0;
            ifg_q      <= '0;
            rd_ptr_q   <= '0;
            len_rd_q   <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pack_len_q <= pack_len_d;
            rd_cnt_q   <= rd_cnt_d;
            ifg_q      <= ifg_d;
            valid_q    <= rd_en;
            if (rd_en)
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            if (len_pop)
                len_rd_q <= len_rd_q + LEN_ONE;
        end
    end

    assign gmii_rx_dv = valid_q;
    assign gmii_rxd   = valid_q ? rd_data_q : 8'h00;
    assign rx_drop    = drop_q;

`ifdef GMII_RX_BUF_DROP_CNT_EN
    logic [15:0] drop_cnt_q;
    always_ff @(posedge clk) begin
        if (rst)
            drop_cnt_q <= '0;
        else if (drop_q && drop_cnt_q != 16'hFFFF)
            drop_cnt_q <= drop_cnt_q + 16'd1;
    end
    assign rx_drop_cnt = drop_cnt_q;
`else
    assign rx_drop_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_gmii_rx_buffer.sv
// Randomized bench for gmii_rx_buffer: a frame-level queue model predicts every replayed byte, burst length and drop.
`timescale 1ns/1ps
module tb_gmii_rx_buffer;

    localparam int DAW = 7;
    localparam int CAP = 1 << DAW;
    localparam int IFG = 12;

    logic        clk = 1'b0;
    logic        rst, en, link, dv;
    logic [7:0]  rxd;
    logic        gmii_rx_dv, rx_drop;
    logic [7:0]  gmii_rxd;
    logic [15:0] rx_drop_cnt;

    int n_cmp = 0, n_err = 0;
    int cyc = 0;
    int exp_drops = 0, drop_seen = 0, drop_cyc = 0;
    int run_len = 0, gap = 0, have_prev = 0, bursts_done = 0, burst_start_cyc = 0;
    int end_cyc = 0, en_drop_cyc = 0;
    logic [7:0] exp_bytes[$];
    int         exp_lens[$];

    gmii_rx_buffer #(.DATA_AW(DAW), .LEN_AW(4), .IFG_CYCLES(IFG)) dut (
        .clk(clk), .rst(rst), .eth_10_100m_en(en), .link(link),
        .e10_100_rx_dv(dv), .e10_100_rxd(rxd),
        .gmii_rx_dv(gmii_rx_dv), .gmii_rxd(gmii_rxd),
        .rx_drop(rx_drop), .rx_drop_cnt(rx_drop_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Output monitor: compares replayed bytes and burst lengths against the model queues.
    always @(negedge clk) begin
        if (rx_drop) begin
            drop_seen++;
            drop_cyc = cyc;
        end
        if (gmii_rx_dv) begin
            if (run_len == 0) begin
                burst_start_cyc = cyc;
                if (have_prev != 0)
                    chk("ifg_gap_ok", (gap >= IFG) ? 32'd1 : 32'd0, 32'd1);
            end
            run_len++;
            if (exp_bytes.size() == 0)
                chk("byte_expected", (exp_bytes.size() != 0) ? 32'd1 : 32'd0, 32'd1);
            else
                chk("burst_byte", {24'h0, gmii_rxd}, {24'h0, exp_bytes.pop_front()});
        end else begin
            if (run_len > 0) begin
                $display("burst: len=%0d at cycle %0d", run_len, cyc);
                chk("burst_len", run_len, (exp_lens.size() != 0) ? exp_lens.pop_front() : 0);
                chk("rxd_idle_zero", {24'h0, gmii_rxd}, 32'h0);
                bursts_done++;
                run_len   = 0;
                gap       = 0;
                have_prev = 1;
            end else begin
                gap++;
            end
        end
    end

    // Drives one frame of n_nib nibbles; en is dropped from nibble en_drop_at onward when it is > 0.
    task automatic send_frame(input int n_nib, input bit incr, input int en_drop_at, input int gap_cyc);
        logic [7:0] fb[$];
        logic [7:0] cur;
        int nbytes;
        bit lost;
        string outcome;
        nbytes = n_nib / 2;
        lost   = 1'b0;
        for (int i = 0; i < (n_nib + 1) / 2; i++)
            fb.push_back(incr ? 8'(i) : 8'($urandom));
        for (int j = 0; j < n_nib; j++) begin
            @(posedge clk); #1;
            if (en_drop_at > 0 && j == en_drop_at) begin
                en = 1'b0;
                en_drop_cyc = cyc;
            end
            cur = fb[j / 2];
            dv  = 1'b1;
            rxd = {4'($urandom), (j % 2 == 1) ? cur[7:4] : cur[3:0]};
            if (!link) lost = 1'b1;
        end
        @(posedge clk); #1;
        dv      = 1'b0;
        rxd     = 8'($urandom);
        en      = 1'b1;
        end_cyc = cyc;
        if (!link) lost = 1'b1;
        if (lost) begin
            outcome = "lost(link)";
        end else if (en_drop_at > 0 && en_drop_at < n_nib) begin
            exp_drops++;
            outcome = "drop(en)";
        end else if (nbytes == 0) begin
            outcome = "silent(empty)";
        end else if (nbytes > CAP) begin
            exp_drops++;
            outcome = "drop(overflow)";
        end else begin
            for (int k = 0; k < nbytes; k++) exp_bytes.push_back(fb[k]);
            exp_lens.push_back(nbytes);
            outcome = "replay";
        end
        $display("frame: nibbles=%0d bytes=%0d outcome=%s", n_nib, nbytes, outcome);
        repeat (gap_cyc - 1) @(posedge clk);
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((exp_lens.size() != 0 || run_len != 0) && t < 5000) begin
            @(posedge clk);
            t++;
        end
        if (t >= 5000) begin
            chk("drain_timeout", t, 0);
            exp_bytes.delete();
            exp_lens.delete();
        end
        repeat (IFG + 5) @(posedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0, b1;
        bit sends_done;
        rst = 1'b1; en = 1'b1; link = 1'b1; dv = 1'b0; rxd = 8'h00;
        repeat (4) @(posedge clk);
        #1;
        chk("reset_dv", {31'h0, gmii_rx_dv}, 32'h0);
        chk("reset_rxd", {24'h0, gmii_rxd}, 32'h0);
        chk("reset_drop", {31'h0, rx_drop}, 32'h0);
        chk("reset_drop_cnt", {16'h0, rx_drop_cnt}, 32'h0);
        rst = 1'b0;
        repeat (3) @(posedge clk);

        // 64-byte incrementing frame and first-byte latency
        send_frame(128, 1'b1, -1, 1);
        wait_drain();
        chk("latency", burst_start_cyc - end_cyc, 3);
        chk("drops_after_64", drop_seen, exp_drops);

        // three back-to-back 60-byte frames
        b0 = bursts_done;
        for (int i = 0; i < 3; i++) send_frame(120, 1'b0, -1, 2);
        wait_drain();
        chk("b2b_bursts", bursts_done - b0, 3);

        // odd nibble count
        send_frame(9, 1'b0, -1, 1);
        wait_drain();

        // overflow by one byte, exact capacity, then a small frame after the rewind
        send_frame(2 * (CAP + 1), 1'b0, -1, 1);
        repeat (5) @(posedge clk);
        chk("overflow_drop", drop_seen, exp_drops);
        wait_drain();
        send_frame(2 * CAP, 1'b0, -1, 1);
        wait_drain();
        send_frame(40, 1'b0, -1, 1);
        wait_drain();
        chk("drops_after_ovf", drop_seen, exp_drops);

        // eth_10_100m_en drops at byte 30 of a 60-byte frame
        b0 = bursts_done;
        send_frame(120, 1'b0, 60, 3);
        chk("abandon_latency", drop_cyc - en_drop_cyc, 1);
        chk("abandon_drops", drop_seen, exp_drops);
        send_frame(120, 1'b0, -1, 1);
        wait_drain();
        chk("abandon_bursts", bursts_done - b0, 1);

        // randomized frames, including zero-byte and one-byte frames
        for (int i = 0; i < 12; i++) begin
            int n;
            n = $urandom_range(200, 1);
            if (i == 3) n = 1;
            if (i == 5) n = 2;
            send_frame(n, 1'b0, -1, $urandom_range(30, 1));
        end
        wait_drain();
        chk("random_drops", drop_seen, exp_drops);

        // link loss during the second of three replays
        b0 = bursts_done;
        sends_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 3; i++) send_frame(120, 1'b0, -1, 2);
                sends_done = 1'b1;
            end
            begin
                int t;
                t = 0;
                while (!(bursts_done == b0 + 1 && run_len >= 10) && t < 3000) begin
                    @(posedge clk);
                    t++;
                end
                chk("link_wait_timeout", (t < 3000) ? 32'd1 : 32'd0, 32'd1);
                #1 link = 1'b0;
                @(posedge clk); #1;
                chk("link_dv_off", {31'h0, gmii_rx_dv}, 32'h0);
                chk("link_rxd_zero", {24'h0, gmii_rxd}, 32'h0);
                exp_bytes.delete();
                exp_lens.delete();
                run_len   = 0;
                have_prev = 0;
                t = 0;
                while (!sends_done && t < 3000) begin
                    @(posedge clk);
                    t++;
                end
                repeat (3) @(posedge clk);
                #1 link = 1'b1;
            end
        join
        b1 = bursts_done;
        repeat (200) @(posedge clk);
        chk("no_burst_after_link", bursts_done - b1, 0);
        chk("link_no_drop", drop_seen, exp_drops);
        send_frame(60, 1'b0, -1, 1);
        wait_drain();
        chk("post_link_burst", bursts_done - b1, 1);

`ifdef GMII_RX_BUF_DROP_CNT_EN
        chk("drop_cnt", {16'h0, rx_drop_cnt}, exp_drops);
`else
        chk("drop_cnt_tied", {16'h0, rx_drop_cnt}, 32'h0);
`endif
        chk("model_drained", exp_bytes.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
